// File: rtl/pri_uart_pkg.sv
// Shared definitions for the UART transmit path.
//
// Contents:
//   uart_state_t : FSM encoding for the transmitter (IDLE/START/DATA/STOP).
//   DATA_BITS    : payload bits per frame.
//   FRAME_BITS   : start + payload + stop bits per frame.
//   clk_div()    : clock cycles per serial bit for a given clock (MHz) and
//                  baud rate (bits/s), truncated.
package pri_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Integer division truncates, so the real baud rate is slightly above the
  // nominal one when the ratio is not exact (50 MHz / 115200 -> 434).
  function automatic int clk_div(input int clock_mhz, input int baud);
    return (clock_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART.
//
// Counts 0..DIV-1 while enabled and emits a one-cycle tick on the cycle the
// count sits at DIV-1; the count then wraps to 0. A synchronous clear forces
// the count to 0 and suppresses the tick so a new bit period starts cleanly.
//
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset (count -> 0)
//   clear_i : synchronous clear, takes priority over en_i
//   en_i    : count enable
//   tick_o  : high for one cycle at the last cycle of each bit period
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i & ~clear_i & at_last;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter.
//
// Two on-chip sources (requester 0 = core debug port, requester 1 =
// heartbeat/status) share one UART TX pin. A round-robin arbiter picks one
// byte at a time while idle, and the byte is sent as 8N1 (start bit, 8 data
// bits LSB first, stop bit) with CLK_DIV clock cycles per bit.
//
// Handshake (valid/ready): a requester raises req_valid[i] with its byte on
// req_data<i> and must hold both stable until it sees req_ready[i] high at a
// rising clock edge; that edge is the transfer. req_ready is combinational,
// only ever high in IDLE and out of reset, and at most one bit is high. With
// both requesters valid, ready goes to the one that did not win last, so
// sustained contention alternates 0,1,0,1. A requester may drop valid before
// being accepted; nothing is transferred in that case.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset; abandons any frame in flight
//   req_valid  : [1:0] per-requester byte valid
//   req_data0  : [7:0] requester 0 byte
//   req_data1  : [7:0] requester 1 byte
//   req_ready  : [1:0] per-requester accept (one-hot or zero)
//   tx         : serial output, idle high, registered
//   busy       : high while a frame is in flight
//   grant_id   : requester whose byte is being / was last sent
module uart_tx_arbiter
  import pri_uart_pkg::*;
#(
  parameter int Clock = 50,      // system clock, MHz
  parameter int Baud  = 115200   // serial rate, bits/s
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  localparam int CLK_DIV = clk_div(Clock, Baud);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_arbiter: CLK_DIV must be at least 2");
  end

  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  // FSM state
  uart_state_t state_q, state_d;

  // Datapath registers
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;      // last-granted requester
  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;

  // Control
  logic sel_id;     // requester that would be granted this cycle
  logic accept;     // handshake completes at the coming edge
  logic bit_tick;   // last cycle of the current bit period

  uart_baud_tick #(
    .DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .en_i    (state_q != IDLE),
    .tick_o  (bit_tick)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA:    if (bit_tick && (bit_idx_q == LAST_BIT)) state_d = STOP;
      STOP:    if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (arbitration and serial bit value)
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready = 2'b00;
    tx_d      = 1'b1;
    // With both valid, favour the requester that did not win last time;
    // otherwise whichever single requester is valid.
    sel_id    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // Gated by rst_n so nothing is offered while reset is asserted.
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready = sel_id ? 2'b10 : 2'b01;
        end
      end
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign accept = |(req_valid & req_ready);

  // ---------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    grant_d   = grant_q;
    last_d    = last_q;
    busy_d    = busy_q;

    if (accept) begin
      shift_d   = sel_id ? req_data1 : req_data0;
      grant_d   = sel_id;
      last_d    = sel_id;
      busy_d    = 1'b1;
      bit_idx_d = '0;
    end

    case (state_q)
      START: if (bit_tick) bit_idx_d = '0;
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: if (bit_tick) busy_d = 1'b0;
      default: ;
    endcase
  end

  // tx_q follows the state one cycle late: the start bit appears on the
  // edge after the accept edge and the line is never driven from inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;   // requester 0 wins the first contention
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Main instance runs at CLK_DIV=4
// (Clock=1 MHz, Baud=250000); a second instance at default parameters
// checks the 434-cycle bit period.
module tb_uart_tx_arbiter;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_data0, req_data1;
  logic [1:0] req_ready;
  logic       tx, busy, grant_id;

  // Default-parameter DUT signals
  logic       rst2_n;
  logic [1:0] valid2;
  logic [7:0] d2_0, d2_1;
  logic [1:0] ready2;
  logic       tx2, busy2, grant2;

  uart_tx_arbiter #(.Clock(1), .Baud(250000)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  uart_tx_arbiter u_def (
    .clk       (clk),
    .rst_n     (rst2_n),
    .req_valid (valid2),
    .req_data0 (d2_0),
    .req_data1 (d2_1),
    .req_ready (ready2),
    .tx        (tx2),
    .busy      (busy2),
    .grant_id  (grant2)
  );

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one cycle after the accept edge. Samples the 40 tx cycles of the
  // frame, checks bit values, busy length and that ready stays low. When
  // pulse_at >= 0, requester 1 raises valid for 3 cycles starting there.
  task automatic check_frame(input string tag, input logic [7:0] b,
                             input logic g, input int pulse_at);
    logic [39:0] obs;
    logic [39:0] exp;
    logic [9:0]  bits;
    int busy_cnt;
    int rdy_bad;
    bits      = {1'b1, b, 1'b0};
    busy_cnt  = 0;
    rdy_bad   = 0;
    last_fall = -1;
    chk({tag, "_grant"}, grant_id, g);
    for (int k = 0; k < 40; k++) begin
      if (pulse_at >= 0 && k == pulse_at)     req_valid = 2'b10;
      if (pulse_at >= 0 && k == pulse_at + 3) req_valid = 2'b00;
      #1;
      if (busy) busy_cnt++;
      if (req_ready != 2'b00) rdy_bad++;
      tick();
      obs[k] = tx;
      exp[k] = bits[k/4];
      if (tx == 1'b0 && last_fall < 0) last_fall = cyc;
    end
    chk({tag, "_bits"}, obs, exp);
    chk({tag, "_busy_len"}, busy_cnt, 40);
    chk({tag, "_ready_low"}, rdy_bad, 0);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int falls[3];
    int idle_bad;
    int n;
    logic g;

    rst_n = 1'b0; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
    rst2_n = 1'b0; valid2 = 2'b00; d2_0 = 8'h00; d2_1 = 8'h00;
    tick(); tick();

    // Reset state; ready must stay low under reset even with a request.
    req_valid = 2'b01;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // Single request from requester 0: 0xA5.
    req_data0 = 8'hA5; req_valid = 2'b01;
    #1;
    chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("single_tx_hold", tx, 1'b1);   // tx falls one edge later
    check_frame("single", 8'hA5, 1'b0, -1);

    // Simultaneous first request after reset: requester 0 wins.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 2'b11; req_data0 = 8'h55; req_data1 = 8'h33;
    #1;
    chk("sim_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    check_frame("sim0", 8'h55, 1'b0, -1);
    #1;
    chk("sim_ready1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check_frame("sim1", 8'h33, 1'b1, -1);

    // Sustained contention: last grant was 1, so 0,1,0,1.
    req_valid = 2'b11; req_data0 = 8'h3C; req_data1 = 8'hC3;
    for (int f = 0; f < 4; f++) begin
      g = f[0];
      #1;
      chk($sformatf("rr%0d_ready", f), req_ready, g ? 2'b10 : 2'b01);
      tick();
      check_frame($sformatf("rr%0d", f), g ? 8'hC3 : 8'h3C, g, -1);
    end

    // Requester 1 alone, held valid: 41-cycle pitch between start bits.
    req_valid = 2'b10; req_data1 = 8'hFF;
    for (int f = 0; f < 3; f++) begin
      #1;
      chk($sformatf("solo%0d_ready", f), req_ready, 2'b10);
      tick();
      check_frame($sformatf("solo%0d", f), 8'hFF, 1'b1, -1);
      falls[f] = last_fall;
    end
    chk("solo_pitch01", falls[1] - falls[0], 41);
    chk("solo_pitch12", falls[2] - falls[1], 41);
    req_valid = 2'b00;

    // Reset during data bit 3 of a requester-0 frame (bit 3 of 0xA5 is 0).
    req_valid = 2'b01; req_data0 = 8'hA5;
    #1;
    chk("mid_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 18; k++) tick();
    chk("mid_tx_bit3", tx, 1'b0);
    rst_n = 1'b0; req_valid = 2'b01;
    tick();
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 2'b00);
    rst_n = 1'b1;
    // Pointer was 0 before reset; reset must give requester 0 priority again.
    req_valid = 2'b11; req_data0 = 8'h96; req_data1 = 8'h69;
    #1;
    chk("post_rst_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check_frame("post_rst", 8'h96, 1'b0, -1);

    // Requester 1 pulses valid mid-frame then withdraws: no transfer.
    req_valid = 2'b01; req_data0 = 8'h81; req_data1 = 8'h42;
    #1;
    chk("wd_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check_frame("withdraw", 8'h81, 1'b0, 5);
    idle_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 2'b00) idle_bad++;
      tick();
    end
    chk("wd_idle", idle_bad, 0);
    chk("wd_grant", grant_id, 1'b0);

    // Default parameters: 434-cycle bit period.
    rst2_n = 1'b1;
    tick();
    valid2 = 2'b01; d2_0 = 8'hFF;
    #1;
    chk("def_ready", ready2, 2'b01);
    tick();
    valid2 = 2'b00;
    n = 0;
    while (tx2 && n < 10) begin tick(); n++; end
    chk("def_fall_latency", n, 1);
    n = 0;
    while (!tx2 && n < 1000) begin tick(); n++; end
    chk("def_start_len", n, 434);
    // Now 435 cycles past the accept edge; busy drops 4340 cycles after it.
    n = 0;
    while (busy2 && n < 5000) begin tick(); n++; end
    chk("def_busy_rest", n, 3905);
    chk("def_grant", grant2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
